game_controller: RTL and testbench
==================================

# game_controller

Top-level sequencer for the sudoku game. Owns the game state register that drives the board updater's `current_state`, the 9×9 cursor and its derived `index`, map selection, the map-load handshake, and win/loss detection from the board updater's `visibilities` and `strikes`. Sits between the button edge detectors and the board updater / map ROM.

## Interface
- `INICIO`, 3'b000: idle/title state.
- `SELECIONAR_MAPA`, 3'b001: map selection.
- `CARREGANDO`, 3'b010: board load; value shared with board updater.
- `NAVEGAR`, 3'b011: cursor navigation.
- `PERCORRER_NUMEROS`, 3'b100: number entry; value shared with board updater.
- `VITORIA`, 3'b101: game won.
- `DERROTA`, 3'b110: game lost.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low; low forces all registers to reset values immediately.
- `up_button`, `down_button`, `left_button`, `right_button`, `a_button`, `b_button` in 1 each: single-cycle pulses, already debounced and edge-detected.
- `map_valid` in 1: map ROM data valid for `map_select`.
- `visibilities` in 162: 2 bits per cell, cell k at `[2k +: 2]`; 2'b11 means solved.
- `strikes` in 2: wrong-entry count from board updater.
- `current_state` out 3: registered game state.
- `index` out 8: `2*(row*9+col)`, range 0..160.
- `cursor_row`, `cursor_col` out 4 each: 0..8.
- `map_select` out 2: chosen map, 0..3.
- `map_req` out 1: high while in `CARREGANDO`.
- `clear_game` out 1: one-cycle pulse on leaving `VITORIA`/`DERROTA`.

## Operation
- Reset values: state `INICIO`, row/col 0, `index` 0, `map_select` 0, `map_req` 0, `clear_game` 0, `check_pending` 0.
- `INICIO`: `a` -> `SELECIONAR_MAPA`.
- `SELECIONAR_MAPA`: `right` increments `map_select` (3 wraps to 0), `left` decrements (0 wraps to 3); `a` -> `CARREGANDO`. `a` has priority over `left`/`right` in the same cycle.
- `CARREGANDO`: `map_req`=1. Leave on the edge where `map_valid`=1 -> `NAVEGAR`, cursor forced to (0,0). No timeout; `map_valid` low holds the state indefinitely.
- `NAVEGAR`: arrows move the cursor with wrap inside row/column (col 8 + `right` -> col 0, same row; row 0 + `up` -> row 8). `a` -> `PERCORRER_NUMEROS` only if the cursor cell visibility is not 2'b11; otherwise ignored. Priority: `a` > `right` > `left` > `down` > `up`; one action per cycle.
- `PERCORRER_NUMEROS`: cursor frozen; `left`/`right`/`up`/`down` ignored by the controller. `b` -> `NAVEGAR`. `a` sets `check_pending`; `b` and `a` together: `b` wins, no check.
- Check cycle, one cycle after `a`, when the board updater's results are registered: `strikes`==3 -> `DERROTA`; else all 81 cells 2'b11 -> `VITORIA`; else cursor cell 2'b11 -> `NAVEGAR`; else stay. Clear `check_pending`. Buttons in the check cycle are ignored.
- `VITORIA`/`DERROTA`: `a` -> `INICIO` with `clear_game`=1 for that cycle; other buttons are ignored.
- Unused encoding 3'b111 -> `INICIO` on the next edge.

## Timing
- All outputs are registered; `index` updates in the same edge as `cursor_row`/`cursor_col`.
- Button-to-state latency: 1 cycle. Entry-to-verdict latency: 2 cycles (`a` edge, then check edge).
- Reset asserted mid-load or mid-check: immediate return to reset values; `check_pending` is discarded.
- The win reduction is combinational over `visibilities` and sampled only in the check cycle.

## Structure
- Shared package `sudoku_pkg`: state encodings (shared with the board updater), `N_CELLS`=81, `GRID`=9, visibility codes (`VIS_HIDDEN`=00, `VIS_SELECTED`=01, `VIS_ERROR`=10, `VIS_SOLVED`=11).
- Sub-module `cursor_9x9`: row/col registers, wrap logic, `index` computation, synchronous clear to (0,0); enabled only in `NAVEGAR`.

## Test plan
- Reset, then `a`, `right`×5, `a`: `map_select`=1, state `CARREGANDO`, `map_req`=1. Raise `map_valid`: next state `NAVEGAR`, `index`=0.
- In `NAVEGAR` at (0,8), press `right`: cursor (0,0). At (0,0), press `up`: cursor (8,0), `index`=144.
- Cursor cell visibility 11, press `a`: state stays `NAVEGAR`. Cell 01, press `a`: `PERCORRER_NUMEROS`; press `b`: `NAVEGAR`.
- In `PERCORRER_NUMEROS`, press `a` with `strikes` driven to 3 on the next cycle: state `DERROTA` 2 cycles after `a`. Press `a`: `clear_game` pulses once, state `INICIO`.
- Set all `visibilities` to 11 in the check cycle: state `VITORIA`. With one cell still 10: state stays `PERCORRER_NUMEROS`.
- Pull `reset` low during `CARREGANDO` with `map_valid`=0: asynchronous return to `INICIO`, `map_req`=0 before the next edge.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared definitions for the sudoku game: state encodings (shared with the
// board updater), grid geometry and per-cell visibility codes.
package sudoku_pkg;

    typedef enum logic [2:0] {
        INICIO            = 3'b000,
        SELECIONAR_MAPA   = 3'b001,
        CARREGANDO        = 3'b010,
        NAVEGAR           = 3'b011,
        PERCORRER_NUMEROS = 3'b100,
        VITORIA           = 3'b101,
        DERROTA           = 3'b110
    } game_state_t;

    localparam int N_CELLS = 81;
    localparam int GRID    = 9;

    localparam logic [1:0] VIS_HIDDEN   = 2'b00;
    localparam logic [1:0] VIS_SELECTED = 2'b01;
    localparam logic [1:0] VIS_ERROR    = 2'b10;
    localparam logic [1:0] VIS_SOLVED   = 2'b11;

endpackage

// File: rtl/cursor_9x9.sv
// 9x9 board cursor: row/col registers with wrap inside the row/column,
// registered board index (2 bits per cell) and a synchronous clear to (0,0).
module cursor_9x9
    import sudoku_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       clear_i,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       left_i,
    input  logic       right_i,
    output logic [3:0] row_o,
    output logic [3:0] col_o,
    output logic [7:0] index_o
);

    localparam logic [3:0] LAST = 4'(GRID - 1);

    logic [3:0] row_q, row_d;
    logic [3:0] col_q, col_d;
    logic [7:0] index_q, index_d;

    // Next cursor position: clear wins, then one move per cycle in the
    // priority order right > left > down > up, wrapping at the edges.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = 4'd0;
            col_d = 4'd0;
        end else if (en_i) begin
            if (right_i)     col_d = (col_q == LAST) ? 4'd0 : col_q + 4'd1;
            else if (left_i) col_d = (col_q == 4'd0) ? LAST : col_q - 4'd1;
            else if (down_i) row_d = (row_q == LAST) ? 4'd0 : row_q + 4'd1;
            else if (up_i)   row_d = (row_q == 4'd0) ? LAST : row_q - 4'd1;
        end
        index_d = 8'(row_d) * 8'd18 + 8'(col_d) * 8'd2;
    end

    // Cursor and index registers update together so index never lags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= 4'd0;
            col_q   <= 4'd0;
            index_q <= 8'd0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            index_q <= index_d;
        end
    end

    assign row_o   = row_q;
    assign col_o   = col_q;
    assign index_o = index_q;

endmodule

// File: rtl/game_controller.sv
// Top-level sudoku sequencer: game state, map selection and load handshake,
// cursor ownership, and win/loss verdict one cycle after a number entry.
module game_controller
    import sudoku_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   up_button,
    input  logic                   down_button,
    input  logic                   left_button,
    input  logic                   right_button,
    input  logic                   a_button,
    input  logic                   b_button,
    input  logic                   map_valid,
    input  logic [2*N_CELLS-1:0]   visibilities,
    input  logic [1:0]             strikes,
    output logic [2:0]             current_state,
    output logic [7:0]             index,
    output logic [3:0]             cursor_row,
    output logic [3:0]             cursor_col,
    output logic [1:0]             map_select,
    output logic                   map_req,
    output logic                   clear_game
);

    game_state_t state_q, state_d;
    logic        check_pending_q, check_pending_d;
    logic [1:0]  map_select_q, map_select_d;
    logic        map_req_q, map_req_d;
    logic        clear_game_q, clear_game_d;

    logic [1:0]  cursorVis;
    logic        allSolved;
    logic        cursorEn;
    logic        cursorClear;

    assign cursorVis   = visibilities[index +: 2];
    assign allSolved   = &visibilities;
    // The a button outranks every arrow, so it blocks cursor motion.
    assign cursorEn    = (state_q == NAVEGAR) && !a_button;
    assign cursorClear = (state_q == CARREGANDO) && map_valid;

    cursor_9x9 u_cursor (
        .clk     (clk),
        .rst_n   (reset),
        .en_i    (cursorEn),
        .clear_i (cursorClear),
        .up_i    (up_button),
        .down_i  (down_button),
        .left_i  (left_button),
        .right_i (right_button),
        .row_o   (cursor_row),
        .col_o   (cursor_col),
        .index_o (index)
    );

    // Next-state, map selection and verdict logic; check cycle ignores buttons.
    always_comb begin
        state_d         = state_q;
        check_pending_d = check_pending_q;
        map_select_d    = map_select_q;
        clear_game_d    = 1'b0;
        case (state_q)
            INICIO: begin
                if (a_button) state_d = SELECIONAR_MAPA;
            end
            SELECIONAR_MAPA: begin
                if (a_button)          state_d      = CARREGANDO;
                else if (right_button) map_select_d = map_select_q + 2'd1;
                else if (left_button)  map_select_d = map_select_q - 2'd1;
            end
            CARREGANDO: begin
                if (map_valid) state_d = NAVEGAR;
            end
            NAVEGAR: begin
                if (a_button && (cursorVis != VIS_SOLVED)) state_d = PERCORRER_NUMEROS;
            end
            PERCORRER_NUMEROS: begin
                if (check_pending_q) begin
                    check_pending_d = 1'b0;
                    if (strikes == 2'd3)              state_d = DERROTA;
                    else if (allSolved)               state_d = VITORIA;
                    else if (cursorVis == VIS_SOLVED) state_d = NAVEGAR;
                end else if (b_button) begin
                    state_d = NAVEGAR;
                end else if (a_button) begin
                    check_pending_d = 1'b1;
                end
            end
            VITORIA, DERROTA: begin
                if (a_button) begin
                    state_d      = INICIO;
                    clear_game_d = 1'b1;
                end
            end
            default: state_d = INICIO;
        endcase
        map_req_d = (state_d == CARREGANDO);
    end

    // Game registers; reset also discards any pending verdict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= INICIO;
            check_pending_q <= 1'b0;
            map_select_q    <= 2'd0;
            map_req_q       <= 1'b0;
            clear_game_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            check_pending_q <= check_pending_d;
            map_select_q    <= map_select_d;
            map_req_q       <= map_req_d;
            clear_game_q    <= clear_game_d;
        end
    end

    assign current_state = state_q;
    assign map_select    = map_select_q;
    assign map_req       = map_req_q;
    assign clear_game    = clear_game_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed, table-driven bench for game_controller plus hand-written
// sequences for asynchronous reset during load and during a pending check.
module tb_game_controller;

    localparam logic [5:0] BU = 6'b100000;
    localparam logic [5:0] BD = 6'b010000;
    localparam logic [5:0] BL = 6'b001000;
    localparam logic [5:0] BR = 6'b000100;
    localparam logic [5:0] BA = 6'b000010;
    localparam logic [5:0] BB = 6'b000001;
    localparam logic [5:0] BN = 6'b000000;

    localparam logic [2:0] SI = 3'd0, SS = 3'd1, SC = 3'd2, SN = 3'd3,
                           SP = 3'd4, SV = 3'd5, SD = 3'd6;

    localparam logic [161:0] V0      = '0;
    localparam logic [161:0] VC0S    = 162'd3;
    localparam logic [161:0] VC0SEL  = 162'd1;
    localparam logic [161:0] VALL    = '1;
    localparam logic [161:0] VALLERR = ~162'd1;

    logic         clk = 1'b0;
    logic         reset;
    logic         up_button, down_button, left_button, right_button, a_button, b_button;
    logic         map_valid;
    logic [161:0] visibilities;
    logic [1:0]   strikes;
    logic [2:0]   current_state;
    logic [7:0]   index;
    logic [3:0]   cursor_row, cursor_col;
    logic [1:0]   map_select;
    logic         map_req, clear_game;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [5:0]   btn;
        logic         mv;
        logic [161:0] vis;
        logic [1:0]   stk;
        logic [2:0]   st;
        logic [3:0]   row;
        logic [3:0]   col;
        logic [7:0]   idx;
        logic [1:0]   ms;
        logic         req;
        logic         clr;
    } vec_t;

    vec_t vecs[$];

    game_controller dut (
        .clk           (clk),
        .reset         (reset),
        .up_button     (up_button),
        .down_button   (down_button),
        .left_button   (left_button),
        .right_button  (right_button),
        .a_button      (a_button),
        .b_button      (b_button),
        .map_valid     (map_valid),
        .visibilities  (visibilities),
        .strikes       (strikes),
        .current_state (current_state),
        .index         (index),
        .cursor_row    (cursor_row),
        .cursor_col    (cursor_col),
        .map_select    (map_select),
        .map_req       (map_req),
        .clear_game    (clear_game)
    );

    always #5 clk = ~clk;

    // Append one vector: inputs for a cycle and the outputs expected after its edge.
    task automatic addVec(input logic [5:0] btn, input logic mv, input logic [161:0] vis,
                          input logic [1:0] stk, input logic [2:0] st, input logic [3:0] row,
                          input logic [3:0] col, input logic [7:0] idx, input logic [1:0] ms,
                          input logic req, input logic clr);
        vec_t v;
        v.btn = btn; v.mv = mv; v.vis = vis; v.stk = stk;
        v.st = st; v.row = row; v.col = col; v.idx = idx;
        v.ms = ms; v.req = req; v.clr = clr;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, wait for the edge, settle #1 after it.
    task automatic applyStimulus(input logic [5:0] btn, input logic mv,
                                 input logic [161:0] vis, input logic [1:0] stk);
        {up_button, down_button, left_button, right_button, a_button, b_button} = btn;
        map_valid    = mv;
        visibilities = vis;
        strikes      = stk;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic checkAll(input string tag, input logic [2:0] st, input logic [3:0] row,
                            input logic [3:0] col, input logic [7:0] idx, input logic [1:0] ms,
                            input logic req, input logic clr);
        checkOutput({tag, ".state"}, 8'(current_state), 8'(st));
        checkOutput({tag, ".row"},   8'(cursor_row),    8'(row));
        checkOutput({tag, ".col"},   8'(cursor_col),    8'(col));
        checkOutput({tag, ".index"}, index,             idx);
        checkOutput({tag, ".map"},   8'(map_select),    8'(ms));
        checkOutput({tag, ".req"},   8'(map_req),       8'(req));
        checkOutput({tag, ".clr"},   8'(clear_game),    8'(clr));
    endtask

    initial begin
        reset = 1'b0;
        {up_button, down_button, left_button, right_button, a_button, b_button} = BN;
        map_valid = 1'b0; visibilities = V0; strikes = 2'd0;

        //      btn      mv  vis      stk   st  row   col   idx    ms  req clr
        addVec(BA,      0, V0,      0, SS, 0, 0, 0,   0, 0, 0);
        addVec(BR,      0, V0,      0, SS, 0, 0, 0,   1, 0, 0);
        addVec(BR,      0, V0,      0, SS, 0, 0, 0,   2, 0, 0);
        addVec(BR,      0, V0,      0, SS, 0, 0, 0,   3, 0, 0);
        addVec(BR,      0, V0,      0, SS, 0, 0, 0,   0, 0, 0);
        addVec(BR,      0, V0,      0, SS, 0, 0, 0,   1, 0, 0);
        addVec(BL,      0, V0,      0, SS, 0, 0, 0,   0, 0, 0);
        addVec(BL,      0, V0,      0, SS, 0, 0, 0,   3, 0, 0);
        addVec(BR,      0, V0,      0, SS, 0, 0, 0,   0, 0, 0);
        addVec(BR,      0, V0,      0, SS, 0, 0, 0,   1, 0, 0);
        addVec(BA | BR, 0, V0,      0, SC, 0, 0, 0,   1, 1, 0);
        addVec(BN,      0, V0,      0, SC, 0, 0, 0,   1, 1, 0);
        addVec(BN,      1, V0,      0, SN, 0, 0, 0,   1, 0, 0);
        addVec(BL,      0, V0,      0, SN, 0, 8, 16,  1, 0, 0);
        addVec(BR,      0, V0,      0, SN, 0, 0, 0,   1, 0, 0);
        addVec(BU,      0, V0,      0, SN, 8, 0, 144, 1, 0, 0);
        addVec(BD,      0, V0,      0, SN, 0, 0, 0,   1, 0, 0);
        addVec(BD,      0, V0,      0, SN, 1, 0, 18,  1, 0, 0);
        addVec(BR | BL, 0, V0,      0, SN, 1, 1, 20,  1, 0, 0);
        addVec(BL | BD, 0, V0,      0, SN, 1, 0, 18,  1, 0, 0);
        addVec(BD | BU, 0, V0,      0, SN, 2, 0, 36,  1, 0, 0);
        addVec(BU,      0, V0,      0, SN, 1, 0, 18,  1, 0, 0);
        addVec(BU,      0, V0,      0, SN, 0, 0, 0,   1, 0, 0);
        addVec(BA,      0, VC0S,    0, SN, 0, 0, 0,   1, 0, 0);
        addVec(BA,      0, VC0SEL,  0, SP, 0, 0, 0,   1, 0, 0);
        addVec(BR,      0, VC0SEL,  0, SP, 0, 0, 0,   1, 0, 0);
        addVec(BB,      0, VC0SEL,  0, SN, 0, 0, 0,   1, 0, 0);
        addVec(BA,      0, VC0SEL,  0, SP, 0, 0, 0,   1, 0, 0);
        addVec(BA | BB, 0, VC0SEL,  0, SN, 0, 0, 0,   1, 0, 0);
        addVec(BN,      0, VC0SEL,  3, SN, 0, 0, 0,   1, 0, 0);
        addVec(BA,      0, VC0SEL,  0, SP, 0, 0, 0,   1, 0, 0);
        addVec(BA,      0, VC0SEL,  0, SP, 0, 0, 0,   1, 0, 0);
        addVec(BB,      0, VC0SEL,  0, SP, 0, 0, 0,   1, 0, 0);
        addVec(BA,      0, VC0SEL,  0, SP, 0, 0, 0,   1, 0, 0);
        addVec(BN,      0, VALLERR, 0, SP, 0, 0, 0,   1, 0, 0);
        addVec(BA,      0, VC0SEL,  0, SP, 0, 0, 0,   1, 0, 0);
        addVec(BN,      0, VC0S,    0, SN, 0, 0, 0,   1, 0, 0);
        addVec(BA,      0, VC0SEL,  0, SP, 0, 0, 0,   1, 0, 0);
        addVec(BA,      0, VC0SEL,  0, SP, 0, 0, 0,   1, 0, 0);
        addVec(BN,      0, VC0SEL,  3, SD, 0, 0, 0,   1, 0, 0);
        addVec(BR,      0, VC0SEL,  3, SD, 0, 0, 0,   1, 0, 0);
        addVec(BA,      0, VC0SEL,  0, SI, 0, 0, 0,   1, 0, 1);
        addVec(BN,      0, V0,      0, SI, 0, 0, 0,   1, 0, 0);
        addVec(BA,      0, V0,      0, SS, 0, 0, 0,   1, 0, 0);
        addVec(BA,      0, V0,      0, SC, 0, 0, 0,   1, 1, 0);
        addVec(BN,      1, V0,      0, SN, 0, 0, 0,   1, 0, 0);
        addVec(BR,      0, V0,      0, SN, 0, 1, 2,   1, 0, 0);
        addVec(BA,      0, V0,      0, SP, 0, 1, 2,   1, 0, 0);
        addVec(BA,      0, V0,      0, SP, 0, 1, 2,   1, 0, 0);
        addVec(BN,      0, VALL,    2, SV, 0, 1, 2,   1, 0, 0);
        addVec(BB,      0, VALL,    0, SV, 0, 1, 2,   1, 0, 0);
        addVec(BA,      0, VALL,    0, SI, 0, 1, 2,   1, 0, 1);

        // Reset values while reset is held, then release away from an edge.
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", SI, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].btn, vecs[i].mv, vecs[i].vis, vecs[i].stk);
            checkAll($sformatf("vec%0d", i), vecs[i].st, vecs[i].row, vecs[i].col,
                     vecs[i].idx, vecs[i].ms, vecs[i].req, vecs[i].clr);
        end

        // Asynchronous reset in the middle of a stalled map load.
        applyStimulus(BA, 0, V0, 0);
        applyStimulus(BR, 0, V0, 0);
        applyStimulus(BA, 0, V0, 0);
        checkAll("preload", SC, 0, 1, 2, 2, 1, 0);
        #2 reset = 1'b0;
        #1;
        checkAll("loadReset", SI, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(BN, 0, V0, 0);
        checkAll("afterLoadReset", SI, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset with a check pending must discard the verdict.
        applyStimulus(BA, 0, V0, 0);
        applyStimulus(BA, 0, V0, 0);
        applyStimulus(BN, 1, V0, 0);
        applyStimulus(BA, 0, VC0SEL, 0);
        applyStimulus(BA, 0, VC0SEL, 0);
        checkAll("prechk", SP, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        checkAll("chkReset", SI, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(BN, 0, VC0SEL, 3);
        checkAll("afterChkReset", SI, 0, 0, 0, 0, 0, 0);
        applyStimulus(BA, 0, VC0SEL, 3);
        checkAll("restart", SS, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
